rr_merge_2to1: RTL and testbench
================================

Name: rr_merge_2to1

Overview:
- Downstream consumer of the two-requester round-robin arbitration scheme.
- Merges two valid/ready input streams into one registered output stream.
- Arbitration is round-robin: on conflict, the channel not served last wins.
- Sits between two producers and a single shared sink, which may stall via out_ready.

Parameters:
- DATA_W, 8, width of the data word on each input and on the output

Ports:
- clk  input  1  clock; all state changes on posedge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- in0_valid  input  1  channel 0 has a word
- in0_data  input  DATA_W  channel 0 word
- in0_last  input  1  channel 0 end-of-burst marker (used only with the optional feature)
- in0_ready  output  1  channel 0 word accepted this cycle when in0_valid & in0_ready
- in1_valid  input  1  channel 1 has a word
- in1_data  input  DATA_W  channel 1 word
- in1_last  input  1  channel 1 end-of-burst marker (used only with the optional feature)
- in1_ready  output  1  channel 1 word accepted this cycle when in1_valid & in1_ready
- out_valid  output  1  output register holds a word
- out_data  output  DATA_W  registered word
- out_src  output  1  source channel of out_data (0 or 1)
- out_ready  input  1  sink accepts the word when out_valid & out_ready

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_src=0.
  - last_served=1, so channel 0 wins the first conflict.
  - lock=0.
- Slot free: can_load = !out_valid | out_ready (combinational; same-cycle drain and refill allowed).
- Grant (combinational, one-hot or zero):
  - Only in0_valid: grant 0.
  - Only in1_valid: grant 1.
  - Both valid: grant the channel != last_served.
  - Neither valid: no grant.
- in0_ready = can_load & grant0; in1_ready = can_load & grant1. Both are never 1 in the same cycle.
- Ready never depends on in*_valid of the same channel beyond the grant computation above.
- Transfer (fire) = chosen valid & ready. On fire, at the next posedge:
  - out_valid=1, out_data and out_src take the chosen word and channel.
  - last_served takes the chosen channel.
- Drain: out_ready & out_valid with no fire → out_valid=0 next cycle; out_data holds its value.
- Stall: out_valid & !out_ready → both readys 0, output register and last_served unchanged.
- last_served changes only on a fire. A cycle with no requests does not move the pointer.
- Latency: one cycle from input fire to out_valid.
- Throughput: 1 word/cycle while out_ready=1.
- Reset asserted mid-stream discards the held word: out_valid drops immediately (asynchronously).

Optional Feature:
- Macro: RR_MERGE_2TO1_BURST_LOCK_EN.
- Defined:
  - A fire with inX_last=0 sets lock=1 and lock_ch=X.
  - While lock=1, grant is forced to lock_ch regardless of the other channel's valid. The other channel's ready stays 0.
  - Lock clears on the fire of lock_ch with last=1.
  - last_served updates on every fire, as without the macro.
  - Reset clears lock.
- Not defined: in*_last are ignored; arbitration is per beat; no lock register exists.

Test Plan:
- Single channel: in0_valid=1, data 0x11,0x22,0x33, out_ready=1 → in0_ready=1 each cycle; out_data 0x11,0x22,0x33 one cycle later, out_src=0.
- Conflict after reset: both valid continuously, in0=0xA0.., in1=0xB0.., out_ready=1 → out_src sequence 0,1,0,1; data alternates A0,B0,A1,B1.
- Arbitration sequence: requests (in1_valid,in0_valid) 01,00,10,11,11,00,11,00,11,11 with out_ready=1 → fired channel per cycle: 0,-,1,0,1,-,0,-,1,0.
- Backpressure: out_ready=0 for 3 cycles with both valid → readys 0; out_data held; last_served frozen; on out_ready=1 the word drains and the next grant goes to the other channel in the same cycle.
- Burst lock (macro on): in0 sends 3 beats, last on the 3rd; in1 valid throughout → three consecutive out_src=0, then out_src=1. With the macro off → out_src alternates 0,1,0,1.
- Async reset: assert rst=0 mid-cycle while out_valid=1 → out_valid=0 before the next edge. After release, the first conflict goes to channel 0.

Source files
------------

// File: rtl/rr_merge_2to1_if.sv
// rr_merge_2to1_if: both producer streams and the shared sink stream of the 2:1 merge.
interface rr_merge_2to1_if #(parameter int DATA_W = 8);
    logic              in0_valid;
    logic              in0_ready;
    logic              in0_last;
    logic [DATA_W-1:0] in0_data;
    logic              in1_valid;
    logic              in1_ready;
    logic              in1_last;
    logic [DATA_W-1:0] in1_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_src;
    logic [DATA_W-1:0] out_data;
    modport slave (
        input  in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_src
    );
    modport master (
        output in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_merge_2to1.sv
// rr_merge_2to1: round-robin merge of two valid/ready streams into one registered output.
// Define RR_MERGE_2TO1_BURST_LOCK_EN to hold the grant on a channel until its last beat.
module rr_merge_2to1 #(
    parameter int DATA_W = 8
) (
    input logic            clk,
    input logic            rst,
    rr_merge_2to1_if.slave bus
);
    logic              out_valid;
    logic              out_src;
    logic [DATA_W-1:0] out_data;
    logic              last_served;
    logic              can_load;
    logic              grant0;
    logic              grant1;
    logic              fire0;
    logic              fire1;
    logic              fire;
    assign can_load = !out_valid || bus.out_ready;
`ifdef RR_MERGE_2TO1_BURST_LOCK_EN
    logic lock;
    logic lock_ch;
    // A locked channel keeps the slot even while it is idle mid-burst
    assign grant0 = lock ? !lock_ch : bus.in0_valid && (!bus.in1_valid || last_served);
    assign grant1 = lock ? lock_ch : bus.in1_valid && (!bus.in0_valid || !last_served);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock    <= 1'b0;
            lock_ch <= 1'b0;
        end else if (fire) begin
            lock    <= fire1 ? !bus.in1_last : !bus.in0_last;
            lock_ch <= fire1;
        end
    end
`else
    logic unused_last;
    assign unused_last = bus.in0_last ^ bus.in1_last;
    assign grant0 = bus.in0_valid && (!bus.in1_valid || last_served);
    assign grant1 = bus.in1_valid && (!bus.in0_valid || !last_served);
`endif
    assign bus.in0_ready = can_load && grant0;
    assign bus.in1_ready = can_load && grant1;
    assign fire0 = bus.in0_valid && bus.in0_ready;
    assign fire1 = bus.in1_valid && bus.in1_ready;
    assign fire  = fire0 || fire1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_src     <= 1'b0;
            last_served <= 1'b1;
        end else if (can_load) begin
            out_valid <= fire;
            if (fire) begin
                out_data    <= fire1 ? bus.in1_data : bus.in0_data;
                out_src     <= fire1;
                last_served <= fire1;
            end
        end
    end
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_src   = out_src;
endmodule

// File: tb/tb_rr_merge_2to1.sv
// tb_rr_merge_2to1: directed and random stimulus against a queue-based reference of the merge.
module tb_rr_merge_2to1;
    localparam int DATA_W = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    rr_merge_2to1_if #(.DATA_W(DATA_W)) bus ();
    rr_merge_2to1 #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    logic [DATA_W:0] exp_q[$];
    bit m_valid = 1'b0;
    bit m_last = 1'b1;
    bit m_lock = 1'b0;
    bit m_lock_ch = 1'b0;
    int fired;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic model_reset();
        exp_q.delete();
        m_valid   = 1'b0;
        m_last    = 1'b1;
        m_lock    = 1'b0;
        m_lock_ch = 1'b0;
    endtask
    // One bus cycle: drive inputs, check readys against the reference, record any accepted word
    task automatic cyc(input bit v0, input bit v1, input logic [DATA_W-1:0] d0,
                       input logic [DATA_W-1:0] d1, input bit l0, input bit l1, input bit ordy);
        bit cl;
        bit fire;
        int g;
        @(negedge clk);
        bus.in0_valid = v0;
        bus.in1_valid = v1;
        bus.in0_data  = d0;
        bus.in1_data  = d1;
        bus.in0_last  = l0;
        bus.in1_last  = l1;
        bus.out_ready = ordy;
        #1;
        cl = !m_valid || ordy;
        if (m_lock) g = int'(m_lock_ch);
        else if (v0 && v1) g = m_last ? 0 : 1;
        else g = v0 ? 0 : (v1 ? 1 : -1);
        chk("out_valid", int'(bus.out_valid), int'(m_valid));
        chk("in0_ready", int'(bus.in0_ready), int'(cl && g == 0));
        chk("in1_ready", int'(bus.in1_ready), int'(cl && g == 1));
        fire  = cl && ((g == 0 && v0) || (g == 1 && v1));
        fired = fire ? g : -1;
        if (fire) begin
            exp_q.push_back({g[0], g == 1 ? d1 : d0});
            m_last = g[0];
`ifdef RR_MERGE_2TO1_BURST_LOCK_EN
            m_lock    = !(g == 1 ? l1 : l0);
            m_lock_ch = g[0];
`endif
        end
        m_valid = fire || (m_valid && !ordy);
    endtask
    task automatic do_reset();
        @(negedge clk);
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask
    initial begin : monitor
        logic [DATA_W:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected got src=%0d data=%0h expected no word", bus.out_src, bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", int'(bus.out_data), int'(e[DATA_W-1:0]));
                    chk("out_src", int'(bus.out_src), int'(e[DATA_W]));
                end
            end
        end
    end
    initial begin
        logic [1:0] arb_req [10] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
        int arb_exp [10] = '{0, -1, 1, 0, 1, -1, 0, -1, 1, 0};
`ifdef RR_MERGE_2TO1_BURST_LOCK_EN
        int burst_exp [4] = '{0, 0, 0, 1};
`else
        int burst_exp [4] = '{0, 1, 0, 1};
`endif
        logic [DATA_W-1:0] n0;
        logic [DATA_W-1:0] n1;
        int beats;
        int nf;
        int g1;
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.in0_data  = '0;
        bus.in1_data  = '0;
        bus.in0_last  = 1'b0;
        bus.in1_last  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_out_src", int'(bus.out_src), 0);
        rst = 1'b1;
        foreach (arb_exp[i]) begin
            if (i < 3) begin
                cyc(1'b1, 1'b0, DATA_W'(8'h11 * (i + 1)), '0, 1'b1, 1'b1, 1'b1);
                chk("single_fire", fired, 0);
            end
        end
        do_reset();
        n0 = 8'hA0;
        n1 = 8'hB0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, n0, n1, 1'b1, 1'b1, 1'b1);
            chk("conflict_src", fired, i % 2);
            if (fired == 0) n0++;
            if (fired == 1) n1++;
        end
        for (int i = 0; i < 10; i++) begin
            cyc(arb_req[i][0], arb_req[i][1], DATA_W'($urandom), DATA_W'($urandom), 1'b1, 1'b1, 1'b1);
            chk("arb_seq", fired, arb_exp[i]);
        end
        cyc(1'b1, 1'b1, 8'hC0, 8'hD0, 1'b1, 1'b1, 1'b1);
        g1 = fired;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 8'hC1, 8'hD1, 1'b1, 1'b1, 1'b0);
            chk("bp_stall", fired, -1);
        end
        cyc(1'b1, 1'b1, 8'hC2, 8'hD2, 1'b1, 1'b1, 1'b1);
        chk("bp_next", fired, 1 - g1);
        do_reset();
        beats = 3;
        nf = 0;
        for (int i = 0; i < 6 && nf < 4; i++) begin
            cyc(beats > 0, 1'b1, DATA_W'(8'h50 + beats), DATA_W'(8'h60 + i), beats == 1, 1'b1, 1'b1);
            if (fired >= 0) begin
                chk("burst_src", fired, burst_exp[nf]);
                nf++;
            end
            if (fired == 0) beats--;
        end
        chk("burst_count", nf, 4);
        cyc(1'b1, 1'b0, 8'h77, 8'h00, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("areset_pre_valid", int'(bus.out_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("areset_valid", int'(bus.out_valid), 0);
        chk("areset_data", int'(bus.out_data), 0);
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, 1'b1, 8'h81, 8'h91, 1'b1, 1'b1, 1'b1);
        chk("areset_first_conflict", fired, 0);
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom), 1'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(0, 9) < 7);
        repeat (4) cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
